// File: rtl/layer_compositor.sv
// Pipelined VGA pixel compositor: fixed-priority colour-keyed layers over a background,
// with a frame-stable round mouse cursor that flashes for a number of frames after a hit.
module layer_compositor #(
    parameter int unsigned              NUM_LAYERS   = 4,
    parameter int unsigned              CW           = 8,
    parameter logic [3*CW-1:0]          KEY_COLOR    = '1,
    parameter logic [NUM_LAYERS-1:0]    KEY_MASK     = '1,
    parameter logic [23:0]              BG_COLOR     = 24'hB4EEB4,
    parameter int unsigned              CURSOR_R     = 6,
    parameter logic [23:0]              CURSOR_COLOR = 24'hDFB5AA,
    parameter logic [23:0]              FLASH_COLOR  = 24'hFF0000,
    parameter int unsigned              FLASH_FRAMES = 8
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         VGA_VS,
    input  logic                         pix_valid,
    input  logic [9:0]                   DrawX,
    input  logic [9:0]                   DrawY,
    input  logic [NUM_LAYERS-1:0]        layer_en,
    input  logic [NUM_LAYERS*3*CW-1:0]   layer_rgb,
    input  logic [9:0]                   MouseX,
    input  logic [9:0]                   MouseY,
    input  logic                         hit,
    output logic [CW-1:0]                VGA_R,
    output logic [CW-1:0]                VGA_G,
    output logic [CW-1:0]                VGA_B,
    output logic                         out_valid,
    output logic                         flashing
);

    localparam int unsigned PW = 3 * CW;
    localparam logic [PW-1:0] BG_PW     = PW'(BG_COLOR);
    localparam logic [PW-1:0] CURSOR_PW = PW'(CURSOR_COLOR);
    localparam logic [PW-1:0] FLASH_PW  = PW'(FLASH_COLOR);
    localparam logic [22:0]   R_SQ      = 23'(CURSOR_R * CURSOR_R);
    localparam logic [7:0]    FLASH_CNT = 8'(FLASH_FRAMES);

    typedef enum logic {IDLE, FLASH} state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            vs_q, vs_d;
    logic            vs_fall;
    logic [9:0]      mx_q, mx_d, my_q, my_d;
    logic            cursor_vis_q, cursor_vis_d;

    logic [PW-1:0]   colour_s1_q, colour_s1_d;
    logic            in_cur_s1_q, in_cur_s1_d;
    logic            pix_valid_s1_q, pix_valid_s1_d;
    logic [PW-1:0]   rgb_q, rgb_d;
    logic            out_valid_q, out_valid_d;

    logic            found;
    logic [10:0]     dx, dy, adx, ady;
    logic [22:0]     dist_sq;

    // vs_q resets low so the first cycle out of reset can never look like a falling edge
    assign vs_fall = vs_q & ~VGA_VS;

    always_comb begin
        vs_d         = VGA_VS;
        mx_d         = vs_fall ? MouseX : mx_q;
        my_d         = vs_fall ? MouseY : my_q;
        cursor_vis_d = cursor_vis_q | vs_fall;
    end

    always_comb begin
        found       = 1'b0;
        colour_s1_d = BG_PW;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (!found && layer_en[i] &&
                !(KEY_MASK[i] && (layer_rgb[i*PW +: PW] == KEY_COLOR))) begin
                found       = 1'b1;
                colour_s1_d = layer_rgb[i*PW +: PW];
            end
        end
    end

    // Offsets are 11-bit two's complement; squaring magnitudes at 23 bits avoids any wrap
    always_comb begin
        dx             = {1'b0, mx_q} - {1'b0, DrawX};
        dy             = {1'b0, my_q} - {1'b0, DrawY};
        adx            = dx[10] ? (~dx + 11'd1) : dx;
        ady            = dy[10] ? (~dy + 11'd1) : dy;
        dist_sq        = 23'(adx) * 23'(adx) + 23'(ady) * 23'(ady);
        in_cur_s1_d    = cursor_vis_q & (dist_sq <= R_SQ);
        pix_valid_s1_d = pix_valid;
    end

    always_comb begin
        if (!pix_valid_s1_q)
            rgb_d = '0;
        else if (in_cur_s1_q)
            rgb_d = flashing ? FLASH_PW : CURSOR_PW;
        else
            rgb_d = colour_s1_q;
        out_valid_d = pix_valid_s1_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_q           <= 1'b0;
            mx_q           <= '0;
            my_q           <= '0;
            cursor_vis_q   <= 1'b0;
            colour_s1_q    <= '0;
            in_cur_s1_q    <= 1'b0;
            pix_valid_s1_q <= 1'b0;
            rgb_q          <= '0;
            out_valid_q    <= 1'b0;
        end else begin
            vs_q           <= vs_d;
            mx_q           <= mx_d;
            my_q           <= my_d;
            cursor_vis_q   <= cursor_vis_d;
            colour_s1_q    <= colour_s1_d;
            in_cur_s1_q    <= in_cur_s1_d;
            pix_valid_s1_q <= pix_valid_s1_d;
            rgb_q          <= rgb_d;
            out_valid_q    <= out_valid_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A hit always reloads the counter, even when it lands on a frame edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = FLASH;
                    cnt_d   = FLASH_CNT;
                end
            end
            FLASH: begin
                if (hit) begin
                    cnt_d = FLASH_CNT;
                end else if (vs_fall) begin
                    if (cnt_q == 8'd1)
                        state_d = IDLE;
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        flashing = (state_q == FLASH);
    end

    assign VGA_R     = rgb_q[PW-1 -: CW];
    assign VGA_G     = rgb_q[2*CW-1 -: CW];
    assign VGA_B     = rgb_q[CW-1 -: CW];
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: layer priority/keying, background, cursor geometry,
// frame latching, flash counting/retrigger and asynchronous reset.
module tb_layer_compositor;

    logic        Clk;
    logic        Reset_n;
    logic        VGA_VS;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY;
    logic [3:0]  layer_en;
    logic [95:0] layer_rgb;
    logic [9:0]  MouseX, MouseY;
    logic        hit;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        out_valid;
    logic        flashing;

    int tests_run;
    int tests_failed;

    layer_compositor dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .VGA_VS    (VGA_VS),
        .pix_valid (pix_valid),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .layer_en  (layer_en),
        .layer_rgb (layer_rgb),
        .MouseX    (MouseX),
        .MouseY    (MouseY),
        .hit       (hit),
        .VGA_R     (VGA_R),
        .VGA_G     (VGA_G),
        .VGA_B     (VGA_B),
        .out_valid (out_valid),
        .flashing  (flashing)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One vs_fall: VGA_VS low for one cycle, then high again
    task automatic frame();
        VGA_VS = 1'b0;
        tick(1);
        VGA_VS = 1'b1;
        tick(1);
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        tick(2);
    endtask

    function automatic logic [23:0] rgb();
        return {VGA_R, VGA_G, VGA_B};
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset_n   = 1'b0;
        VGA_VS    = 1'b1;
        pix_valid = 1'b0;
        DrawX     = '0;
        DrawY     = '0;
        layer_en  = '0;
        layer_rgb = '0;
        MouseX    = '0;
        MouseY    = '0;
        hit       = 1'b0;
        #1;
        chk("reset_rgb", rgb(), 24'h0);
        chk("reset_valid", 24'(out_valid), 24'h0);
        chk("reset_flash", 24'(flashing), 24'h0);
        tick(3);
        Reset_n = 1'b1;
        tick(2);

        // T1: L0 disabled, L1 keyed out, L2 opaque
        layer_rgb = {24'h777777, 24'h123456, 24'hFFFFFF, 24'hAAAAAA};
        layer_en  = 4'b0110;
        pix_valid = 1'b1;
        DrawX = 10'd500;
        DrawY = 10'd500;
        tick(1);
        chk("latency_t1", rgb(), 24'h0);
        tick(1);
        chk("t1_layer2", rgb(), 24'h123456);
        chk("t1_valid", 24'(out_valid), 24'h1);

        layer_rgb = {24'h777777, 24'h123456, 24'hABCDEF, 24'hFFFFFF};
        layer_en  = 4'b1111;
        tick(2);
        chk("t1_key_l0", rgb(), 24'hABCDEF);
        layer_en = 4'b1000;
        tick(2);
        chk("t1_l3_only", rgb(), 24'h777777);

        // T2: background, then blanked
        layer_en = 4'b0000;
        tick(2);
        chk("t2_bg", rgb(), 24'hB4EEB4);
        pix_valid = 1'b0;
        tick(2);
        chk("t2_blank_rgb", rgb(), 24'h0);
        chk("t2_blank_valid", 24'(out_valid), 24'h0);
        pix_valid = 1'b1;

        // T3: cursor hidden before first frame latch
        MouseX = 10'd100;
        MouseY = 10'd100;
        pixel(10'd100, 10'd100);
        chk("t3_hidden", rgb(), 24'hB4EEB4);
        pixel(10'd0, 10'd0);
        chk("t3_hidden_origin", rgb(), 24'hB4EEB4);
        frame();
        pixel(10'd106, 10'd100);
        chk("t3_edge_r6", rgb(), 24'hDFB5AA);
        pixel(10'd105, 10'd104);
        chk("t3_outside_41", rgb(), 24'hB4EEB4);
        pixel(10'd94, 10'd100);
        chk("t3_left_edge", rgb(), 24'hDFB5AA);
        pixel(10'd100, 10'd107);
        chk("t3_below_r7", rgb(), 24'hB4EEB4);
        MouseX = 10'd500;
        pixel(10'd106, 10'd100);
        chk("t3_no_tearing", rgb(), 24'hDFB5AA);

        // T4: no modular wrap at screen edges
        MouseX = 10'd3;
        MouseY = 10'd3;
        frame();
        pixel(10'd1020, 10'd3);
        chk("t4_no_wrap", rgb(), 24'hB4EEB4);
        pixel(10'd0, 10'd3);
        chk("t4_near_edge", rgb(), 24'hDFB5AA);

        // T5: flash for exactly 8 frames
        pixel(10'd3, 10'd3);
        hit = 1'b1;
        tick(1);
        hit = 1'b0;
        chk("t5_flash_on", 24'(flashing), 24'h1);
        tick(2);
        chk("t5_flash_color", rgb(), 24'hFF0000);
        repeat (7) frame();
        chk("t5_after7", 24'(flashing), 24'h1);
        frame();
        chk("t5_after8", 24'(flashing), 24'h0);
        tick(2);
        chk("t5_idle_color", rgb(), 24'hDFB5AA);

        // T5: hit on the 5th vs_fall reloads instead of decrementing
        hit = 1'b1;
        tick(1);
        hit = 1'b0;
        repeat (4) frame();
        VGA_VS = 1'b0;
        hit    = 1'b1;
        tick(1);
        hit    = 1'b0;
        VGA_VS = 1'b1;
        tick(1);
        repeat (7) frame();
        chk("t5_retrig_7", 24'(flashing), 24'h1);
        frame();
        chk("t5_retrig_8", 24'(flashing), 24'h0);

        // T6: asynchronous reset during FLASH
        hit = 1'b1;
        tick(1);
        hit = 1'b0;
        tick(2);
        chk("t6_pre_flash", rgb(), 24'hFF0000);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t6_async_rgb", rgb(), 24'h0);
        chk("t6_async_valid", 24'(out_valid), 24'h0);
        chk("t6_async_flash", 24'(flashing), 24'h0);
        tick(2);
        Reset_n = 1'b1;
        pixel(10'd3, 10'd3);
        chk("t6_cursor_hidden", rgb(), 24'hB4EEB4);
        frame();
        pixel(10'd3, 10'd3);
        chk("t6_cursor_back", rgb(), 24'hDFB5AA);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
